alu_seq: RTL and testbench

- Parametrised, handshaked successor of the 8-bit datapath ALU.
- Operand width set by WIDTH. Opcode widened to 4 bits; the original 8 opcodes keep their encodings.
- New operations: carry-chained add/sub, XOR, multi-bit shifts and an iterative multiply. Some of these take several cycles, so the block has a valid/ready front end and a held result.
- Sits between the register file and the writeback/flags logic of the CPU datapath.

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/alu_seq_iter.sv | 103 ++++++++++
 rtl/alu_seq.sv | 163 ++++++++++++++++
 tb/tb_alu_seq.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, flag bit positions, FSM encoding.
// Optional multiply is enabled by the ALU_MUL_EN macro (see alu_seq.sv / alu_seq_iter.sv).
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_NOT  = 4'd4;
  localparam logic [3:0] OP_CMP  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_ADC  = 4'd8;
  localparam logic [3:0] OP_SBC  = 4'd9;
  localparam logic [3:0] OP_XOR  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_SHRN = 4'd12;
  localparam logic [3:0] OP_SHLN = 4'd13;
  localparam logic [3:0] OP_ASRN = 4'd14;
  localparam logic [3:0] OP_RSVD = 4'd15;

  localparam int unsigned FLAG_C = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_O = 1;
  localparam int unsigned FLAG_Z = 0;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Assemble the {C,N,O,Z} flag vector from its component bits
  function automatic logic [3:0] pack_flags(input logic c, input logic n,
                                            input logic o, input logic z);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_C] = c;
    f[FLAG_N] = n;
    f[FLAG_O] = o;
    f[FLAG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// Multi-cycle engine: one-bit-per-cycle shifts and, with ALU_MUL_EN, a shift-add multiply.
// res_c/carry_c show the value the accumulator takes on the current edge; done_c marks the last step.
module alu_seq_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] ld,
`ifdef ALU_MUL_EN
  input  logic [WIDTH-1:0] mcand_in,
`endif
  input  logic [SHW-1:0]   amt,
  output logic [WIDTH-1:0] res_c,
  output logic             carry_c,
  output logic             done_c
);

  localparam int unsigned CW = SHW + 1;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] nxt_acc;
  logic [3:0]       op_q;
  logic             carry;
`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] nxt_hi;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH:0]   mul_sum;
`endif

  // One iteration step of the latched operation
  always_comb begin
    nxt_acc = acc;
    carry   = 1'b0;
`ifdef ALU_MUL_EN
    nxt_hi  = hi;
    mul_sum = '0;
`endif
    case (op_q)
      OP_SHLN: begin
        carry   = acc[WIDTH-1];
        nxt_acc = {acc[WIDTH-2:0], 1'b0};
      end
      OP_SHRN: begin
        carry   = acc[0];
        nxt_acc = {1'b0, acc[WIDTH-1:1]};
      end
      OP_ASRN: begin
        carry   = acc[0];
        nxt_acc = {acc[WIDTH-1], acc[WIDTH-1:1]};
      end
`ifdef ALU_MUL_EN
      // Low half of the product shifts through acc while the multiplier bits are consumed
      OP_MUL: begin
        mul_sum = {1'b0, hi} + (acc[0] ? {1'b0, mcand} : (WIDTH+1)'(0));
        nxt_hi  = mul_sum[WIDTH:1];
        nxt_acc = {mul_sum[0], acc[WIDTH-1:1]};
        carry   = |mul_sum[WIDTH:1];
      end
`endif
      default: ;
    endcase
  end

  assign res_c   = nxt_acc;
  assign carry_c = carry;
  assign done_c  = (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      acc  <= '0;
      op_q <= '0;
`ifdef ALU_MUL_EN
      hi    <= '0;
      mcand <= '0;
`endif
    end else if (start) begin
      acc  <= ld;
      op_q <= op;
`ifdef ALU_MUL_EN
      hi    <= '0;
      mcand <= mcand_in;
      cnt   <= (op == OP_MUL) ? CW'(WIDTH) : CW'(amt);
`else
      cnt   <= CW'(amt);
`endif
    end else if (cnt != '0) begin
      acc <= nxt_acc;
      cnt <= cnt - CW'(1);
`ifdef ALU_MUL_EN
      hi  <= nxt_hi;
`endif
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked, parametrised datapath ALU: single-cycle ops here, multi-cycle ops in alu_seq_iter.
// Define ALU_MUL_EN to build opcode 11 as an iterative multiply; otherwise it acts as reserved.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       flags
);

  localparam int unsigned W1 = WIDTH + 1;

  logic [1:0]       state;
  logic [1:0]       nxt_state;
  logic [WIDTH-1:0] res_d;
  logic [3:0]       flags_d;
  logic [SHW-1:0]   amt;
  logic             accept_c;
  logic             shift_op_c;
  logic             long_c;
  logic             start_c;
  logic             cin_c;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   dif_w;
  logic             o_add;
  logic             o_sub;
  logic [WIDTH-1:0] s_res;
  logic             s_c;
  logic             s_o;
  logic [WIDTH-1:0] ld_c;
  logic [WIDTH-1:0] iter_res_c;
  logic             iter_carry_c;
  logic             iter_done_c;

  assign amt        = in_B[SHW-1:0];
  assign accept_c   = in_valid && (state == IDLE);
  assign shift_op_c = (op == OP_SHRN) || (op == OP_SHLN) || (op == OP_ASRN);
`ifdef ALU_MUL_EN
  assign long_c     = (shift_op_c && (amt != '0)) || (op == OP_MUL);
  assign ld_c       = (op == OP_MUL) ? in_B : in_A;
`else
  assign long_c     = shift_op_c && (amt != '0);
  assign ld_c       = in_A;
`endif
  assign start_c    = accept_c && long_c;

  // Carry-in only participates in the chained forms
  assign cin_c = ((op == OP_ADC) || (op == OP_SBC)) && flags[FLAG_C];
  assign sum_w = {1'b0, in_A} + {1'b0, in_B} + W1'(cin_c);
  assign dif_w = {1'b0, in_A} - {1'b0, in_B} - W1'(cin_c);
  assign o_add = (in_A[WIDTH-1] == in_B[WIDTH-1]) && (sum_w[WIDTH-1] != in_A[WIDTH-1]);
  assign o_sub = (in_A[WIDTH-1] != in_B[WIDTH-1]) && (dif_w[WIDTH-1] != in_A[WIDTH-1]);

  // Single-cycle result; zero-amount N-shifts pass A through with C=0
  always_comb begin
    s_res = '0;
    s_c   = 1'b0;
    s_o   = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        s_res = sum_w[WIDTH-1:0];
        s_c   = sum_w[WIDTH];
        s_o   = o_add;
      end
      OP_SUB, OP_SBC: begin
        s_res = dif_w[WIDTH-1:0];
        s_c   = dif_w[WIDTH];
        s_o   = o_sub;
      end
      OP_OR:   s_res = in_A | in_B;
      OP_AND:  s_res = in_A & in_B;
      OP_XOR:  s_res = in_A ^ in_B;
      OP_NOT:  s_res = ~in_A;
      OP_CMP:  s_res = WIDTH'(in_A == in_B);
      OP_SHR: begin
        s_res = {1'b0, in_A[WIDTH-1:1]};
        s_c   = in_A[0];
      end
      OP_SHL: begin
        s_res = {in_A[WIDTH-2:0], 1'b0};
        s_c   = in_A[WIDTH-1];
      end
      OP_SHRN, OP_SHLN, OP_ASRN: s_res = in_A;
      default: ;
    endcase
  end

  alu_seq_iter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_c),
    .op       (op),
    .ld       (ld_c),
`ifdef ALU_MUL_EN
    .mcand_in (in_A),
`endif
    .amt      (amt),
    .res_c    (iter_res_c),
    .carry_c  (iter_carry_c),
    .done_c   (iter_done_c)
  );

  // Next state; out/flags are only reloaded on entry to DONE
  always_comb begin
    nxt_state = state;
    res_d     = out;
    flags_d   = flags;
    case (state)
      IDLE: begin
        if (accept_c) begin
          if (long_c) begin
            nxt_state = BUSY;
          end else begin
            nxt_state = DONE;
            res_d     = s_res;
            flags_d   = pack_flags(s_c, s_res[WIDTH-1], s_o, s_res == '0);
          end
        end
      end
      BUSY: begin
        if (iter_done_c) begin
          nxt_state = DONE;
          res_d     = iter_res_c;
          flags_d   = pack_flags(iter_carry_c, iter_res_c[WIDTH-1], 1'b0, iter_res_c == '0);
        end
      end
      DONE: begin
        if (out_ready) nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      out   <= '0;
      flags <= '0;
    end else begin
      state <= nxt_state;
      out   <= res_d;
      flags <= flags_d;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8); expectations adapt to ALU_MUL_EN.
module tb_alu_seq;
  import alu_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_A;
  logic [7:0] in_B;
  logic [3:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_w;
  logic [3:0] flags;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_A      (in_A),
    .in_B      (in_B),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_w),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op, measure accept-to-out_valid latency, check result, then consume it
  task automatic run_op(input string tag, input logic [3:0] o, input logic [7:0] a,
                        input logic [7:0] b, input int exp_lat,
                        input logic [7:0] exp_out, input logic [3:0] exp_flg);
    int lat;
    @(negedge clk);
    in_valid = 1'b1; op = o; in_A = a; in_B = b; out_ready = 1'b0;
    check({tag, ".in_ready"}, 8'(in_ready), 8'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, 8'(lat), 8'(exp_lat));
    check({tag, ".out"}, out_w, exp_out);
    check({tag, ".flags"}, 8'(flags), 8'(exp_flg));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".released"}, 8'({out_valid, in_ready}), 8'b01);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_A = '0; in_B = '0; op = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.out", out_w, 8'h00);
    check("reset.flags", 8'(flags), 8'h00);
    check("reset.out_valid", 8'(out_valid), 8'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset.in_ready", 8'(in_ready), 8'd1);

    // Arithmetic, carry chain through flags[C]
    run_op("add_ovf", OP_ADD, 8'h7F, 8'h01, 1, 8'h80, 4'b0110);
    run_op("sub_borrow", OP_SUB, 8'h00, 8'h01, 1, 8'hFF, 4'b1100);
    run_op("sbc_cin1", OP_SBC, 8'h05, 8'h02, 1, 8'h02, 4'b0000);
    run_op("adc_cin0", OP_ADC, 8'hFF, 8'h00, 1, 8'hFF, 4'b0100);
    run_op("shr_c", OP_SHR, 8'h01, 8'h00, 1, 8'h00, 4'b1001);
    run_op("adc_cin1", OP_ADC, 8'hFF, 8'h00, 1, 8'h00, 4'b1001);
    run_op("sub_ovf", OP_SUB, 8'h80, 8'h01, 1, 8'h7F, 4'b0010);

    // SHLN with a stalled consumer and ignored in_valid while not idle
    @(negedge clk);
    in_valid = 1'b1; op = OP_SHLN; in_A = 8'h81; in_B = 8'd3; out_ready = 1'b0;
    @(negedge clk);
    op = OP_ADD; in_A = 8'h11; in_B = 8'h22;
    for (int i = 1; i <= 5; i++) begin
      check($sformatf("shln.out_valid[%0d]", i), 8'(out_valid), (i >= 4) ? 8'd1 : 8'd0);
      check($sformatf("shln.in_ready[%0d]", i), 8'(in_ready), 8'd0);
      if (i < 5) @(negedge clk);
    end
    in_valid = 1'b0;
    check("shln.out", out_w, 8'h08);
    check("shln.flags", 8'(flags), 8'h0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("shln.released", 8'({out_valid, in_ready}), 8'b01);
    check("shln.hold", out_w, 8'h08);

    run_op("asrn", OP_ASRN, 8'h90, 8'd2, 3, 8'hE4, 4'b0100);
    run_op("shrn_zero", OP_SHRN, 8'h5A, 8'd0, 1, 8'h5A, 4'b0000);
    run_op("shl_c", OP_SHL, 8'hC1, 8'h00, 1, 8'h82, 4'b1100);
    run_op("xor", OP_XOR, 8'hF0, 8'hFF, 1, 8'h0F, 4'b0000);
    run_op("and", OP_AND, 8'hF0, 8'h3C, 1, 8'h30, 4'b0000);
    run_op("or", OP_OR, 8'h01, 8'h80, 1, 8'h81, 4'b0100);
    run_op("not", OP_NOT, 8'h0F, 8'h00, 1, 8'hF0, 4'b0100);
    run_op("cmp_eq", OP_CMP, 8'h33, 8'h33, 1, 8'h01, 4'b0000);
    run_op("cmp_ne", OP_CMP, 8'h33, 8'h34, 1, 8'h00, 4'b0001);
    run_op("rsvd", OP_RSVD, 8'hFF, 8'hFF, 1, 8'h00, 4'b0001);
`ifdef ALU_MUL_EN
    run_op("mul_hi", OP_MUL, 8'h10, 8'h20, 9, 8'h00, 4'b1001);
    run_op("mul_lo", OP_MUL, 8'h0F, 8'h0F, 9, 8'hE1, 4'b0100);
`else
    run_op("mul_rsvd", OP_MUL, 8'h10, 8'h20, 1, 8'h00, 4'b0001);
`endif
    run_op("pre_rst", OP_SUB, 8'h80, 8'h01, 1, 8'h7F, 4'b0010);

    // Reset during the third BUSY cycle
    @(negedge clk);
`ifdef ALU_MUL_EN
    in_valid = 1'b1; op = OP_MUL; in_A = 8'h03; in_B = 8'h05;
`else
    in_valid = 1'b1; op = OP_SHLN; in_A = 8'hFF; in_B = 8'd7;
`endif
    @(negedge clk);
    in_valid = 1'b0;
    check("midrst.busy", 8'(in_ready), 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst.in_ready", 8'(in_ready), 8'd1);
    check("midrst.out_valid", 8'(out_valid), 8'd0);
    check("midrst.out", out_w, 8'h00);
    check("midrst.flags", 8'(flags), 8'h00);
    run_op("post_rst_add", OP_ADD, 8'h02, 8'h03, 1, 8'h05, 4'b0000);
    run_op("post_rst_shln", OP_SHLN, 8'h01, 8'd2, 3, 8'h04, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
